pbit_sweep_scheduler: RTL and testbench

- Sequences Gibbs-sampling updates for a network of p-bits.
- Issues one-hot single-cycle update enables in fixed index order. Each enable is followed by a programmable settle window so the fixed-point synapse (multiply/add/clamp) feeding the next p-bit can settle.
- Counts complete sweeps, captures the p-bit state vector at the end of each sweep, and hands it out over a valid/ready interface.
- Sits between the top-level network and its p-bit instances, replacing the free-running divided-clock sequencer.

---
 rtl/pbit_sweep_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_pbit_sweep_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_sweep_scheduler.sv
// pbit_sweep_scheduler
// Walks through the p-bits in fixed index order, one single-cycle update
// enable at a time. After each enable it waits a programmable number of idle
// cycles so the synapse feeding the next p-bit can settle. At the end of each
// complete sweep it captures the p-bit state vector and offers it to a
// consumer over a valid/ready handshake.
module pbit_sweep_scheduler #(
  parameter int NUM_PBITS = 3,
  parameter int SETTLE_W  = 4,
  parameter int SWEEP_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 stop,
  input  logic [SETTLE_W-1:0]  settle_cycles,
  input  logic [SWEEP_W-1:0]   num_sweeps,
  input  logic [NUM_PBITS-1:0] pbit_state,
  output logic [NUM_PBITS-1:0] en,
  output logic                 busy,
  output logic [SWEEP_W-1:0]   sweep_count,
  output logic [NUM_PBITS-1:0] sample,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 done
);

  localparam int IDX_W = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PBITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    SETTLE,
    SWEEP_END
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [SETTLE_W-1:0]  settle_lim_q, settle_lim_d;
  logic [SWEEP_W-1:0]   sweep_lim_q, sweep_lim_d;
  logic                 stop_pending_q, stop_pending_d;
  logic [NUM_PBITS-1:0] en_q, en_d;
  logic                 busy_q, busy_d;
  logic [SWEEP_W-1:0]   sweep_count_q, sweep_count_d;
  logic [NUM_PBITS-1:0] sample_q, sample_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 done_q, done_d;
  logic                 advance;

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    settle_cnt_d   = settle_cnt_q;
    settle_lim_d   = settle_lim_q;
    sweep_lim_d    = sweep_lim_q;
    stop_pending_d = stop_pending_q;
    sweep_count_d  = sweep_count_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    done_d         = 1'b0;
    advance        = 1'b0;

    // A consumer accept drops valid unless a capture below re-asserts it.
    if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end

    // Stop only matters during a run; the sweep in progress always finishes.
    if ((state_q != IDLE) && stop) begin
      stop_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          settle_lim_d   = settle_cycles;
          sweep_lim_d    = num_sweeps;
          idx_d          = '0;
          sweep_count_d  = '0;
          overrun_d      = 1'b0;
          stop_pending_d = 1'b0;
          state_d        = FIRE;
        end
      end
      FIRE: begin
        if (settle_lim_q != '0) begin
          settle_cnt_d = settle_lim_q - SETTLE_W'(1);
          state_d      = SETTLE;
        end else begin
          advance = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      SWEEP_END: begin
        sample_d       = pbit_state;
        sample_valid_d = 1'b1;
        if (sample_valid_q && !sample_ready) begin
          overrun_d = 1'b1;
        end
        sweep_count_d = sweep_count_q + SWEEP_W'(1);
        if (stop_pending_q || ((sweep_lim_q != '0) && (sweep_count_d == sweep_lim_q))) begin
          state_d        = IDLE;
          done_d         = 1'b1;
          stop_pending_d = 1'b0;
        end else begin
          idx_d   = '0;
          state_d = FIRE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving the settle window: next p-bit, or close the sweep after the last one.
    if (advance) begin
      if (idx_q < LAST_IDX) begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = FIRE;
      end else begin
        state_d = SWEEP_END;
      end
    end

    en_d   = (state_d == FIRE) ? (NUM_PBITS'(1) << idx_d) : '0;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any run on the next edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      settle_cnt_q   <= '0;
      settle_lim_q   <= '0;
      sweep_lim_q    <= '0;
      stop_pending_q <= 1'b0;
      en_q           <= '0;
      busy_q         <= 1'b0;
      sweep_count_q  <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      settle_cnt_q   <= settle_cnt_d;
      settle_lim_q   <= settle_lim_d;
      sweep_lim_q    <= sweep_lim_d;
      stop_pending_q <= stop_pending_d;
      en_q           <= en_d;
      busy_q         <= busy_d;
      sweep_count_q  <= sweep_count_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      done_q         <= done_d;
    end
  end

  assign en           = en_q;
  assign busy         = busy_q;
  assign sweep_count  = sweep_count_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// tb_pbit_sweep_scheduler
// Directed bench for the p-bit sweep scheduler. Expected values are worked
// out by hand from the sweep timing: with settle count S and N p-bits a sweep
// is N*(1+S)+1 cycles, the first enable shows up right after the start edge,
// and the capture of sweep k becomes visible one cycle after its SWEEP_END.
module tb_pbit_sweep_scheduler;

  localparam int N  = 3;
  localparam int SW = 4;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          stop;
  logic [SW-1:0] settle_cycles;
  logic [CW-1:0] num_sweeps;
  logic [N-1:0]  pbit_state;
  logic [N-1:0]  en;
  logic          busy;
  logic [CW-1:0] sweep_count;
  logic [N-1:0]  sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          done;

  int errorCount = 0;
  int checkCount = 0;
  int oneHotBad  = 0;
  int donePulses = 0;
  int enActive   = 0;

  pbit_sweep_scheduler #(
    .NUM_PBITS(N),
    .SETTLE_W (SW),
    .SWEEP_W  (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .stop         (stop),
    .settle_cycles(settle_cycles),
    .num_sweeps   (num_sweeps),
    .pbit_state   (pbit_state),
    .en           (en),
    .busy         (busy),
    .sweep_count  (sweep_count),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .done         (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance n clock edges, looking at outputs 1 time unit after each edge.
  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (!$onehot0(en)) oneHotBad++;
      if (done) donePulses++;
      if (en != '0) enActive++;
    end
  endtask

  // Launch a run; on return the bench sits one cycle after the start edge.
  task automatic applyStimulus(input logic [SW-1:0] s, input logic [CW-1:0] l);
    settle_cycles = s;
    num_sweeps    = l;
    start         = 1'b1;
    stepCycles(1);
    start         = 1'b0;
  endtask

  // Directed scenarios in sequence.
  initial begin
    RST           = 1'b1;
    start         = 1'b0;
    stop          = 1'b0;
    settle_cycles = '0;
    num_sweeps    = '0;
    pbit_state    = '0;
    sample_ready  = 1'b1;
    stepCycles(2);
    checkOutput("reset_en", en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_count", sweep_count, 0);
    checkOutput("reset_valid", sample_valid, 0);
    checkOutput("reset_done", done, 0);
    RST = 1'b0;
    stepCycles(1);

    $display("[TB] basic sequencing, S=2 L=2");
    pbit_state = 3'b101;
    applyStimulus(4'd2, 16'd2);
    checkOutput("basic_en_t1", en, 3'b001);
    checkOutput("basic_busy_t1", busy, 1);
    stepCycles(3);
    checkOutput("basic_en_t4", en, 3'b010);
    stepCycles(3);
    checkOutput("basic_en_t7", en, 3'b100);
    stepCycles(3);
    checkOutput("basic_en_t10", en, 3'b000);
    checkOutput("basic_count_t10", sweep_count, 0);
    stepCycles(1);
    checkOutput("basic_count_t11", sweep_count, 1);
    checkOutput("basic_sample_t11", sample, 3'b101);
    checkOutput("basic_valid_t11", sample_valid, 1);
    checkOutput("basic_en_t11", en, 3'b001);
    pbit_state = 3'b011;
    stepCycles(10);
    checkOutput("basic_done_t21", done, 1);
    checkOutput("basic_busy_t21", busy, 0);
    checkOutput("basic_count_t21", sweep_count, 2);
    checkOutput("basic_sample_t21", sample, 3'b011);
    stepCycles(1);
    checkOutput("basic_done_t22", done, 0);
    checkOutput("basic_valid_t22", sample_valid, 0);
    checkOutput("basic_count_hold", sweep_count, 2);

    $display("[TB] zero settle, L=1");
    pbit_state = 3'b110;
    applyStimulus(4'd0, 16'd1);
    checkOutput("zero_en_t1", en, 3'b001);
    stepCycles(1);
    checkOutput("zero_en_t2", en, 3'b010);
    stepCycles(1);
    checkOutput("zero_en_t3", en, 3'b100);
    stepCycles(1);
    checkOutput("zero_en_t4", en, 3'b000);
    checkOutput("zero_busy_t4", busy, 1);
    stepCycles(1);
    checkOutput("zero_done_t5", done, 1);
    checkOutput("zero_count_t5", sweep_count, 1);
    checkOutput("zero_sample_t5", sample, 3'b110);
    stepCycles(2);

    $display("[TB] stop during sweep 3, S=1 L=0");
    pbit_state = 3'b010;
    applyStimulus(4'd1, 16'd0);
    stepCycles(16);
    checkOutput("stop_en_t17", en, 3'b010);
    checkOutput("stop_count_t17", sweep_count, 2);
    donePulses = 0;
    stop = 1'b1;
    stepCycles(1);
    stop = 1'b0;
    stepCycles(4);
    checkOutput("stop_done_t22", done, 1);
    checkOutput("stop_busy_t22", busy, 0);
    checkOutput("stop_count_t22", sweep_count, 3);
    enActive = 0;
    stepCycles(10);
    checkOutput("stop_no_more_en", enActive, 0);
    checkOutput("stop_done_once", donePulses, 1);

    $display("[TB] backpressure, S=0 L=2");
    sample_ready = 1'b0;
    pbit_state   = 3'b001;
    applyStimulus(4'd0, 16'd2);
    stepCycles(4);
    checkOutput("bp_valid_t5", sample_valid, 1);
    checkOutput("bp_sample_t5", sample, 3'b001);
    checkOutput("bp_overrun_t5", overrun, 0);
    pbit_state = 3'b110;
    stepCycles(4);
    checkOutput("bp_done_t9", done, 1);
    checkOutput("bp_overrun_t9", overrun, 1);
    checkOutput("bp_sample_t9", sample, 3'b110);
    checkOutput("bp_valid_t9", sample_valid, 1);
    sample_ready = 1'b1;
    stepCycles(1);
    sample_ready = 1'b0;
    checkOutput("bp_valid_after_accept", sample_valid, 0);
    checkOutput("bp_overrun_sticky", overrun, 1);
    stepCycles(3);
    checkOutput("bp_overrun_idle", overrun, 1);

    $display("[TB] capture/accept collision");
    pbit_state = 3'b010;
    applyStimulus(4'd0, 16'd2);
    checkOutput("coll_overrun_cleared", overrun, 0);
    stepCycles(4);
    checkOutput("coll_valid_t5", sample_valid, 1);
    checkOutput("coll_sample_t5", sample, 3'b010);
    pbit_state = 3'b111;
    stepCycles(3);
    sample_ready = 1'b1;
    stepCycles(1);
    checkOutput("coll_valid_t9", sample_valid, 1);
    checkOutput("coll_sample_t9", sample, 3'b111);
    checkOutput("coll_overrun_t9", overrun, 0);
    stepCycles(1);
    checkOutput("coll_valid_t10", sample_valid, 0);
    sample_ready = 1'b0;

    $display("[TB] reset during SETTLE");
    pbit_state = 3'b101;
    applyStimulus(4'd3, 16'd0);
    stepCycles(15);
    checkOutput("rst_pre_busy", busy, 1);
    checkOutput("rst_pre_count", sweep_count, 1);
    checkOutput("rst_pre_valid", sample_valid, 1);
    checkOutput("rst_pre_en", en, 3'b000);
    RST = 1'b1;
    stepCycles(1);
    RST = 1'b0;
    checkOutput("rst_en", en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", sweep_count, 0);
    checkOutput("rst_sample", sample, 0);
    checkOutput("rst_valid", sample_valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_done", done, 0);
    enActive = 0;
    stepCycles(5);
    checkOutput("rst_idle_en", enActive, 0);
    checkOutput("rst_idle_busy", busy, 0);

    $display("[TB] start and input changes while busy, S=1 L=3");
    sample_ready = 1'b1;
    applyStimulus(4'd1, 16'd3);
    stepCycles(3);
    start         = 1'b1;
    settle_cycles = 4'd0;
    num_sweeps    = 16'd1;
    stepCycles(1);
    start = 1'b0;
    stepCycles(16);
    checkOutput("busy_start_t21_busy", busy, 1);
    checkOutput("busy_start_t21_count", sweep_count, 2);
    checkOutput("busy_start_t21_en", en, 3'b000);
    stepCycles(1);
    checkOutput("busy_start_done_t22", done, 1);
    checkOutput("busy_start_count_t22", sweep_count, 3);
    checkOutput("busy_start_busy_t22", busy, 0);

    checkOutput("en_onehot0", oneHotBad, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
